// File: rtl/rnn_pkg.sv
// rnn_pkg: shared constants, layer ids and sequencer state type for the RNN denoise datapath.
package rnn_pkg;
  localparam int NUM_LAYERS = 6;
  localparam int FLOAT_W = 32;
  localparam int FEAT_N = 42;
  localparam int GAIN_N = 22;
  localparam int LID_W = 3;
  localparam logic [LID_W-1:0] L_IN_DENSE = 3'd0;
  localparam logic [LID_W-1:0] L_VAD_GRU = 3'd1;
  localparam logic [LID_W-1:0] L_VAD_DENSE = 3'd2;
  localparam logic [LID_W-1:0] L_NOISE_GRU = 3'd3;
  localparam logic [LID_W-1:0] L_DN_GRU = 3'd4;
  localparam logic [LID_W-1:0] L_DN_DENSE = 3'd5;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_t;
endpackage

// File: rtl/rnn_seq_watchdog.sv
// rnn_seq_watchdog: one-cycle timeout pulse once a layer has run TIMEOUT cycles without completing.
module rnn_seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_kick,
  output logic o_timeout
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || !i_en || i_kick) ? '0 : r_cnt + 1'b1;
  // WAIT is entered one cycle after layer_start, so TIMEOUT-2 counted WAIT cycles make TIMEOUT since start
  assign o_timeout = i_en & ~i_kick & (r_cnt == CW'(TIMEOUT - 2));
endmodule

// File: rtl/rnn_layer_sequencer.sv
// rnn_layer_sequencer: frame-level controller stepping the shared layer engine through six layers.
// Optional watchdog abort enabled by defining RNN_SEQ_WATCHDOG_EN.
module rnn_layer_sequencer
  import rnn_pkg::*;
#(
  parameter int FCNT_W = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              feat_load,
  output logic              layer_start,
  output logic [LID_W-1:0]  layer_id,
  input  logic              layer_done,
  input  logic              clear_req,
  output logic              gru_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err
);
  seq_state_t r_state, w_next;
  logic [LID_W-1:0] r_layer_id;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic r_layer_start, r_gru_clear, r_out_valid, r_busy, r_clr_pend;
  logic w_accept, w_last, w_to_idle, w_pend, w_timeout;
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end
  assign in_ready = (r_state == IDLE) & ~r_gru_clear;
  assign w_accept = in_valid & in_ready;
  assign feat_load = w_accept;
  assign w_last = r_layer_id == L_DN_DENSE;
  assign w_to_idle = (r_state != IDLE) & (w_next == IDLE);
  assign w_pend = r_clr_pend | clear_req;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_accept ? ISSUE : IDLE;
      ISSUE: w_next = WAIT;
      WAIT:  w_next = w_timeout ? IDLE : layer_done ? (w_last ? DONE : ISSUE) : WAIT;
      DONE:  w_next = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_layer_id <= L_IN_DENSE;
      r_layer_start <= 1'b0;
      r_gru_clear <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy <= 1'b0;
      r_clr_pend <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_layer_start <= w_next == ISSUE;
      r_out_valid <= w_next == DONE;
      r_busy <= w_next != IDLE;
      // clears requested mid-frame are deferred to the first IDLE cycle
      r_gru_clear <= (r_state == IDLE) ? clear_req & ~w_accept : w_to_idle & w_pend;
      r_clr_pend <= (r_state == IDLE) ? clear_req & w_accept : w_pend & ~w_to_idle;
      if (w_accept)
        r_layer_id <= L_IN_DENSE;
      else if (r_state == WAIT && layer_done && !w_last)
        r_layer_id <= r_layer_id + 3'd1;
      if (r_state == DONE && out_ready)
        r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end
  assign layer_start = r_layer_start;
  assign layer_id = r_layer_id;
  assign gru_clear = r_gru_clear;
  assign out_valid = r_out_valid;
  assign busy = r_busy;
  assign frame_cnt = r_frame_cnt;
`ifdef RNN_SEQ_WATCHDOG_EN
  logic r_err;
  rnn_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .i_en(r_state == WAIT),
    .i_kick(layer_done),
    .o_timeout(w_timeout)
  );
  always_ff @(posedge clk)
    r_err <= rst ? 1'b0 : r_err | w_timeout;
  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rnn_layer_sequencer.sv
// tb_rnn_layer_sequencer: directed bench for rnn_layer_sequencer (FCNT_W=4, TIMEOUT=16).
// Watchdog scenario is selected by RNN_SEQ_WATCHDOG_EN.
module tb_rnn_layer_sequencer;
  import rnn_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, layer_done = 1'b0, clear_req = 1'b0, out_ready = 1'b1;
  logic in_ready, feat_load, layer_start, gru_clear, out_valid, busy, err;
  logic [2:0] layer_id;
  logic [3:0] frame_cnt;
  int nvec = 0, nfail = 0, cyc = 0, exp_fc = 0, t_prev = 0;
  int lat [6];
  always #5 clk = ~clk;
  rnn_layer_sequencer #(.FCNT_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .feat_load(feat_load),
    .layer_start(layer_start), .layer_id(layer_id), .layer_done(layer_done), .clear_req(clear_req),
    .gru_clear(gru_clear), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_cnt(frame_cnt), .err(err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic layer(input int id, input int l, input bit clr);
    chk("layer_start", layer_start, 1);
    chk("layer_id", layer_id, id);
    chk("gru_clear_mid", gru_clear, 0);
    chk("busy_mid", busy, 1);
    clear_req = clr;
    repeat (l) begin
      tick;
      clear_req = 1'b0;
    end
    chk("layer_start_pulse", layer_start, 0);
    chk("layer_id_hold", layer_id, id);
    chk("gru_clear_wait", gru_clear, 0);
    layer_done = 1'b1;
    tick;
    layer_done = 1'b0;
  endtask
  task automatic frame(input int clr_at, input int hold);
    int t0, exp_lat;
    t0 = cyc;
    exp_lat = 1;
    in_valid = 1'b1;
    #1;
    chk("in_ready_accept", in_ready, 1);
    chk("feat_load", feat_load, 1);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      layer(i, lat[i], i == clr_at);
      exp_lat += lat[i] + 1;
    end
    chk("out_valid_rise", out_valid, 1);
    chk("accept_to_valid", cyc - t0, exp_lat);
    out_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      #1;
      chk("out_valid_hold", out_valid, 1);
      chk("in_ready_hold", in_ready, 0);
      chk("feat_load_hold", feat_load, 0);
      chk("frame_cnt_hold", frame_cnt, exp_fc);
      tick;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick;
    exp_fc = (exp_fc + 1) % 16;
    chk("out_valid_fall", out_valid, 0);
    chk("frame_cnt", frame_cnt, exp_fc);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_feat_load", feat_load, 0);
    chk("rst_layer_start", layer_start, 0);
    chk("rst_gru_clear", gru_clear, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_layer_id", layer_id, 0);
    lat = '{1, 1, 1, 1, 1, 1};
    frame(-1, 0);
    lat = '{5, 3, 1, 7, 2, 4};
    frame(-1, 10);
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    chk("idle_clear", gru_clear, 1);
    chk("idle_clear_ready", in_ready, 0);
    tick;
    chk("idle_clear_end", gru_clear, 0);
    chk("idle_clear_ready_end", in_ready, 1);
    lat = '{1, 1, 1, 1, 1, 1};
    frame(3, 0);
    chk("deferred_clear", gru_clear, 1);
    in_valid = 1'b1;
    #1;
    chk("deferred_clear_ready", in_ready, 0);
    chk("deferred_clear_noload", feat_load, 0);
    tick;
    in_valid = 1'b0;
    chk("deferred_clear_end", gru_clear, 0);
    chk("deferred_clear_ready_end", in_ready, 1);
    chk("deferred_clear_busy", busy, 0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    layer(0, 1, 1'b0);
    layer(1, 1, 1'b0);
    chk("l2_start", layer_start, 1);
    chk("l2_id", layer_id, 2);
    tick;
    chk("l2_wait_busy", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_layer_start", layer_start, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_frame_cnt", frame_cnt, 0);
    chk("mrst_layer_id", layer_id, 0);
    chk("mrst_err", err, 0);
    layer_done = 1'b1;
    tick;
    layer_done = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_layer_start", layer_start, 0);
    chk("stray_layer_id", layer_id, 0);
    chk("stray_out_valid", out_valid, 0);
    exp_fc = 0;
    frame(-1, 0);
`ifdef RNN_SEQ_WATCHDOG_EN
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    layer(0, 1, 1'b0);
    chk("wd_start", layer_start, 1);
    chk("wd_id", layer_id, 1);
    repeat (15) tick;
    chk("wd_err_early", err, 0);
    chk("wd_busy_early", busy, 1);
    tick;
    chk("wd_err", err, 1);
    chk("wd_busy", busy, 0);
    chk("wd_out_valid", out_valid, 0);
    chk("wd_frame_cnt", frame_cnt, exp_fc);
    chk("wd_in_ready", in_ready, 1);
    frame(-1, 0);
    chk("wd_err_sticky", err, 1);
`else
    lat = '{1, 40, 1, 1, 1, 1};
    frame(-1, 0);
    chk("no_wd_err", err, 0);
    lat = '{1, 1, 1, 1, 1, 1};
`endif
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_fc = 0;
    chk("wrap_rst_err", err, 0);
    for (int f = 0; f < 17; f++) begin
      if (f > 0) chk("issue_rate", cyc - t_prev, 14);
      t_prev = cyc;
      frame(-1, 0);
    end
    chk("wrap_frame_cnt", frame_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
